// File: rtl/crossing_reg_rx.sv
// ---------------------------------------------------------------------------
// crossing_reg_rx
//
// Destination-side receiver for a toggle-handshake register crossing.
//
// The source domain holds a word stable in a no-reset crossing register and
// flips a request toggle. This block runs entirely on CLK. It synchronizes the
// toggle, captures the word into a one-deep holding register and returns an
// acknowledge toggle to the source. Downstream logic consumes the word with a
// valid/dequeue handshake. A full holding register stalls the acknowledge,
// which is how backpressure reaches the source.
//
// Parameters
//   width       data word width (>= 1)
//   syncStages  synchronizer depth on sTOGGLE (>= 2)
//
// Ports
//   CLK      in   destination clock; all state updates on posedge
//   RST      in   synchronous, active-high reset
//   sTOGGLE  in   request toggle from the source domain (asynchronous)
//   sD_IN    in   source crossing register; stable while a request is pending
//   dACK     out  acknowledge toggle; toggle value of the last captured word
//   dD_OUT   out  holding register contents
//   dVALID   out  holding register full
//   dDEQ     in   consumer takes dD_OUT this cycle; ignored when dVALID=0
//
// Configuration macro
//   CROSSING_RX_DATA_RESET_EN
//     defined   : dD_OUT is cleared by RST.
//     undefined : dD_OUT is an enable-only register. RST leaves it unchanged.
//                 In simulation it starts as the alternating pattern
//                 {...2'b10}, unless BSV_NO_INITIAL_BLOCKS is defined.
//   dVALID, dACK and the synchronizer chain are reset in both builds.
//
// All outputs come straight from flops. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module crossing_reg_rx #(
  parameter int width      = 1,
  parameter int syncStages = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sTOGGLE,
  input  logic [width-1:0] sD_IN,
  output logic             dACK,
  output logic [width-1:0] dD_OUT,
  output logic             dVALID,
  input  logic             dDEQ
);

  // Synchronizer chain; bit 0 samples the asynchronous toggle.
  logic [syncStages-1:0] sync_q;
  logic [syncStages-1:0] sync_d;

  // Handshake state.
  logic ack_q;
  logic ack_d;
  logic valid_q;
  logic valid_d;

  // Holding register.
  logic [width-1:0] data_d;

`ifndef CROSSING_RX_DATA_RESET_EN
`ifndef BSV_NO_INITIAL_BLOCKS
  // Alternating 1010... pattern, LSB = 0, used as the simulation start value
  // of the unreset data register so that uncaptured data is recognizable.
  function automatic logic [width-1:0] alt_pattern();
    logic [width-1:0] p;
    p = '0;
    for (int i = 0; i < width; i++) begin
      p[i] = i[0];
    end
    return p;
  endfunction

  localparam logic [width-1:0] ALT_PAT = alt_pattern();

  logic [width-1:0] data_q = ALT_PAT;
`else
  logic [width-1:0] data_q;
`endif
`else
  logic [width-1:0] data_q;
`endif

  // Decoded handshake conditions.
  logic sync_tog;
  logic pend;
  logic cap;

  assign sync_tog = sync_q[syncStages-1];

  // A request is pending while the synchronized toggle differs from the last
  // acknowledged toggle. It can be taken when the holding register is empty
  // or is being emptied on this same edge.
  assign pend = (sync_tog != ack_q);
  assign cap  = pend && (!valid_q || dDEQ);

  // Next-state logic for the synchronizer, handshake and holding register.
  always_comb begin
    sync_d  = {sync_q[syncStages-2:0], sTOGGLE};
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;

    if (cap) begin
      // A dequeue on the same edge is absorbed here: the old word leaves
      // and the new word loads, so valid stays high.
      valid_d = 1'b1;
      ack_d   = sync_tog;
      data_d  = sD_IN;
    end else if (dDEQ && valid_q) begin
      // The consumer drains the word. The data keeps its old value.
      valid_d = 1'b0;
    end else begin
      // Either full with no dequeue (source stays stalled) or idle.
      valid_d = valid_q;
    end

    // Reset discards any in-flight word. Without a data reset, the data
    // register must keep its contents through RST rather than capture.
    if (RST) begin
      data_d = data_q;
    end else begin
      data_d = data_d;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  // Holding register; reset only in the data-reset build.
  always_ff @(posedge CLK) begin
`ifdef CROSSING_RX_DATA_RESET_EN
    if (RST) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
`else
    data_q <= data_d;
`endif
  end

  assign dACK   = ack_q;
  assign dVALID = valid_q;
  assign dD_OUT = data_q;

endmodule

// File: tb/tb_crossing_reg_rx.sv
// ---------------------------------------------------------------------------
// tb_crossing_reg_rx
//
// Directed self-checking bench for crossing_reg_rx with width=8 and
// syncStages=2. Inputs change 1 time unit after a rising edge. Outputs are
// sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_crossing_reg_rx;

  logic       CLK;
  logic       RST;
  logic       sTOGGLE;
  logic [7:0] sD_IN;
  logic       dACK;
  logic [7:0] dD_OUT;
  logic       dVALID;
  logic       dDEQ;

  int n_checks;
  int n_errors;

  crossing_reg_rx #(
    .width      (8),
    .syncStages (2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .sTOGGLE (sTOGGLE),
    .sD_IN   (sD_IN),
    .dACK    (dACK),
    .dD_OUT  (dD_OUT),
    .dVALID  (dVALID),
    .dDEQ    (dDEQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] rx_words [$];
  logic       src_tog;
  int         sent;
  bit         found;

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST      = 1'b1;
    sTOGGLE  = 1'b0;
    sD_IN    = 8'h00;
    dDEQ     = 1'b0;

    #1;
`ifndef CROSSING_RX_DATA_RESET_EN
`ifndef BSV_NO_INITIAL_BLOCKS
    check_eq("time0_data", {24'd0, dD_OUT}, 32'h0000_00AA);
`endif
`endif

    // Reset state.
    tick();
    tick();
    check_eq("rst_valid", {31'd0, dVALID}, 32'd0);
    check_eq("rst_ack",   {31'd0, dACK},   32'd0);
`ifdef CROSSING_RX_DATA_RESET_EN
    check_eq("rst_data_cleared", {24'd0, dD_OUT}, 32'h0000_0000);
`else
`ifndef BSV_NO_INITIAL_BLOCKS
    check_eq("rst_data_kept", {24'd0, dD_OUT}, 32'h0000_00AA);
`endif
`endif
    RST = 1'b0;
    tick();

    // Single transfer: three edges from toggle to valid.
    sD_IN   = 8'h5A;
    sTOGGLE = 1'b1;
    tick();
    tick();
    check_eq("single_not_yet", {31'd0, dVALID}, 32'd0);
    tick();
    check_eq("single_valid", {31'd0, dVALID}, 32'd1);
    check_eq("single_data",  {24'd0, dD_OUT}, 32'h5A);
    check_eq("single_ack",   {31'd0, dACK},   32'd1);
    dDEQ = 1'b1;
    tick();
    dDEQ = 1'b0;
    check_eq("single_deq_valid", {31'd0, dVALID}, 32'd0);
    check_eq("single_deq_ack",   {31'd0, dACK},   32'd1);

    // Return to a clean reset state with the toggle at 0.
    sTOGGLE = 1'b0;
    RST     = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("rst2_ack", {31'd0, dACK}, 32'd0);
    tick();
    tick();

    // Backpressure: a second word waits until the first is dequeued.
    sD_IN   = 8'h11;
    sTOGGLE = 1'b1;
    tick();
    tick();
    tick();
    check_eq("bp_first_valid", {31'd0, dVALID}, 32'd1);
    check_eq("bp_first_data",  {24'd0, dD_OUT}, 32'h11);
    sD_IN   = 8'h22;
    sTOGGLE = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("bp_hold_ack",   {31'd0, dACK},   32'd1);
      check_eq("bp_hold_data",  {24'd0, dD_OUT}, 32'h11);
      check_eq("bp_hold_valid", {31'd0, dVALID}, 32'd1);
    end
    dDEQ = 1'b1;
    tick();
    dDEQ = 1'b0;
    check_eq("bp_reload_data",  {24'd0, dD_OUT}, 32'h22);
    check_eq("bp_reload_valid", {31'd0, dVALID}, 32'd1);
    check_eq("bp_reload_ack",   {31'd0, dACK},   32'd0);
    dDEQ = 1'b1;
    tick();
    dDEQ = 1'b0;
    check_eq("bp_drain_valid", {31'd0, dVALID}, 32'd0);

    // Back-to-back: the source flips as soon as it sees its acknowledge.
    // The consumer always dequeues, so each valid cycle is one distinct word.
    rx_words.delete();
    src_tog = sTOGGLE;
    sent    = 0;
    dDEQ    = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (dVALID) begin
        rx_words.push_back(dD_OUT);
      end
      if ((sent < 16) && (dACK == src_tog)) begin
        sD_IN   = sent[7:0];
        src_tog = ~src_tog;
        sTOGGLE = src_tog;
        sent++;
      end
      tick();
    end
    dDEQ = 1'b0;
    check_eq("b2b_count", rx_words.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < rx_words.size()) begin
        check_eq("b2b_word", {24'd0, rx_words[i]}, i);
      end else begin
        check_eq("b2b_missing_word", 32'hFFFF_FFFF, i);
      end
    end

    // Reset mid-operation: one word held, a second toggle in the chain.
    sD_IN   = 8'h33;
    sTOGGLE = ~sTOGGLE;
    tick();
    tick();
    tick();
    check_eq("mid_pre_valid", {31'd0, dVALID}, 32'd1);
    check_eq("mid_pre_data",  {24'd0, dD_OUT}, 32'h33);
    sD_IN   = 8'h44;
    sTOGGLE = ~sTOGGLE;
    tick();
    RST     = 1'b1;
    sTOGGLE = 1'b0;
    tick();
    RST = 1'b0;
    check_eq("mid_rst_valid", {31'd0, dVALID}, 32'd0);
    check_eq("mid_rst_ack",   {31'd0, dACK},   32'd0);
`ifdef CROSSING_RX_DATA_RESET_EN
    check_eq("mid_rst_data", {24'd0, dD_OUT}, 32'h00);
`else
    check_eq("mid_rst_data", {24'd0, dD_OUT}, 32'h33);
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("mid_idle_valid", {31'd0, dVALID}, 32'd0);
      check_eq("mid_idle_ack",   {31'd0, dACK},   32'd0);
    end

    // Reset released with the toggle high: treated as a pending request.
    RST     = 1'b1;
    sTOGGLE = 1'b1;
    sD_IN   = 8'hC3;
    tick();
    RST   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found) begin
        tick();
        found = dVALID;
      end
    end
    check_eq("rst_tog1_valid", {31'd0, found},  32'd1);
    check_eq("rst_tog1_data",  {24'd0, dD_OUT}, 32'hC3);
    check_eq("rst_tog1_ack",   {31'd0, dACK},   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
